// File: rtl/sp1_ram_arb.sv
// rtl/sp1_ram_arb.sv - two-port round-robin arbiter/sequencer with clear sweep for a 64x32 single-port RAM
module sp1_ram_arb #(
    parameter int AW = 6,
    parameter int DW = 32,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_din,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_din,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW-1:0] LAST_ADR = '1;
    localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] cnt;
    logic          last;
    logic          p1_v, p1_id, p2_v, p2_id;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_din;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= CLEAR;
        else      state_q <= state_d;
    end

    // last = 1 means requester 1 was granted most recently, so requester 0 wins a tie
    always_comb begin
        state_d = state_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        case (state_q)
            CLEAR: if (cnt == LAST_ADR) state_d = RUN;
            RUN: begin
                if (rst) begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last;
                        m1_gnt = !last;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign sel_we  = m1_gnt ? m1_we  : m0_we;
    assign sel_adr = m1_gnt ? m1_adr : m0_adr;
    assign sel_din = m1_gnt ? m1_din : m0_din;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            last    <= 1'b1;
            ram_cs  <= 1'b0;
            ram_we  <= 1'b0;
            ram_adr <= '0;
            ram_din <= '0;
            p1_v    <= 1'b0;
            p1_id   <= 1'b0;
            p2_v    <= 1'b0;
            p2_id   <= 1'b0;
        end else begin
            p1_v  <= 1'b0;
            p2_v  <= p1_v;
            p2_id <= p1_id;
            if (state_q == CLEAR) begin
                ram_cs  <= 1'b1;
                ram_we  <= 1'b1;
                ram_adr <= cnt;
                ram_din <= CLR_VAL;
                cnt     <= cnt + ONE;
            end else if (m0_gnt || m1_gnt) begin
                ram_cs  <= 1'b1;
                ram_we  <= sel_we;
                ram_adr <= sel_adr;
                ram_din <= sel_din;
                last    <= m1_gnt;
                p1_v    <= !sel_we;
                p1_id   <= m1_gnt;
            end else begin
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
            end
        end
    end

    assign busy      = !rst || (state_q == CLEAR);
    assign m0_rvalid = p2_v && !p2_id;
    assign m1_rvalid = p2_v && p2_id;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_sp1_ram_arb.sv
// tb/tb_sp1_ram_arb.sv - directed self-checking bench for sp1_ram_arb with a behavioural RAM
module tb_sp1_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [5:0]  m0_adr;
    logic [31:0] m0_din, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [5:0]  m1_adr;
    logic [31:0] m1_din, m1_rdata;
    logic        ram_cs, ram_we;
    logic [5:0]  ram_adr;
    logic [31:0] ram_din, ram_dout;
    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    sp1_ram_arb dut (
        .clk(clk), .rst(rst), .busy(busy),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_adr] <= ram_din;
            else        ram_dout <= mem[ram_adr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit m, input bit we, input logic [5:0] adr, input logic [31:0] din);
        int n;
        if (m) begin m1_req = 1'b1; m1_we = we; m1_adr = adr; m1_din = din; end
        else   begin m0_req = 1'b1; m0_we = we; m0_adr = adr; m0_din = din; end
        #1;
        n = 0;
        while (!(m ? m1_gnt : m0_gnt) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("issue_gnt", {31'b0, (m ? m1_gnt : m0_gnt)}, 32'd1);
        @(negedge clk);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, n0, n1, first;
        logic prev;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | i;
        ram_dout = 32'hFFFF_FFFF;
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 6'h2A; m0_din = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 6'h2A; m1_din = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ram_cs",  {31'b0, ram_cs}, 0);
        chk("rst_ram_we",  {31'b0, ram_we}, 0);
        chk("rst_ram_adr", {26'b0, ram_adr}, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_rvalid",  {30'b0, m1_rvalid, m0_rvalid}, 0);
        chk("rst_gnt",     {30'b0, m1_gnt, m0_gnt}, 0);
        chk("rst_busy",    {31'b0, busy}, 1);

        // clear sweep: edges 0..63 write 0 to 0..63 with both requests held
        rst = 1'b1;
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); #1;
            if (!(ram_cs && ram_we && ram_adr == 6'(i) && ram_din == 32'h0)) errs++;
            if (i < 63 && (!busy || m0_gnt || m1_gnt)) errs++;
        end
        chk("clear_sweep", errs, 0);
        chk("clear_busy_low", {31'b0, busy}, 0);
        chk("first_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        @(negedge clk); #1;
        chk("first_cmd", {ram_cs, ram_we, ram_adr}, {1'b1, 1'b0, 6'h2A});
        chk("second_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
        m0_req = 1'b0;
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk("clr_rd0_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
        chk("clr_rd0_data", m0_rdata, 32'h0);
        @(negedge clk); #1;
        chk("clr_rd1_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd2);
        chk("clr_rd1_data", m1_rdata, 32'h0);

        // single requester read latency
        issue(0, 1, 6'h05, 32'hDEADBEEF);
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 6'h05;
        #1;
        chk("lat_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        chk("lat_t1_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("lat_t2_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
        chk("lat_t2_data", m0_rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("lat_t3_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);

        // round robin: last grant was m0, so m1 wins the first tie
        n0 = 0; n1 = 0; errs = 0; prev = 1'b0; first = -1;
        for (int c = 0; c < 16; c++) begin
            m0_req = (n0 < 8); m0_we = 1'b1; m0_adr = 6'h10 + 6'(n0); m0_din = 32'hA000_0000 + n0;
            m1_req = (n1 < 8); m1_we = 1'b1; m1_adr = 6'h20 + 6'(n1); m1_din = 32'hA100_0000 + n1;
            #1;
            if ((m0_gnt ^ m1_gnt) !== 1'b1) errs++;
            if (c > 0 && m1_gnt == prev) errs++;
            if (c == 0) first = int'(m1_gnt);
            prev = m1_gnt;
            if (m0_gnt) n0++;
            if (m1_gnt) n1++;
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_alternate", errs, 0);
        chk("rr_first_m1", first, 1);
        chk("rr_count_m0", n0, 8);
        chk("rr_count_m1", n1, 8);
        issue(0, 0, 6'h27, 32'h0);
        @(negedge clk); #1;
        chk("rr_readback", m0_rdata, 32'hA100_0007);

        // read-after-write across requesters
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 6'h3F; m1_din = 32'h12345678;
        #1;
        chk("raw_wgnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
        @(negedge clk);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 6'h3F;
        #1;
        chk("raw_rgnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        @(negedge clk);
        m0_req = 1'b0;
        @(negedge clk); #1;
        chk("raw_valid", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
        chk("raw_data", m0_rdata, 32'h12345678);

        // mixed read ids: m0 reads 0x01, m1 reads 0x02, alternating
        issue(0, 1, 6'h01, 32'h11111111);
        issue(1, 1, 6'h02, 32'h22222222);
        errs = 0;
        for (int k = 0; k < 6; k++) begin
            m0_req = (k < 4) && (k % 2 == 0); m0_we = 1'b0; m0_adr = 6'h01;
            m1_req = (k < 4) && (k % 2 == 1); m1_we = 1'b0; m1_adr = 6'h02;
            #1;
            if (k < 4 && (k % 2 == 0 ? !m0_gnt : !m1_gnt)) errs++;
            if (k >= 2) begin
                if ((k % 2 == 0) && !(m0_rvalid && !m1_rvalid && m0_rdata == 32'h11111111)) errs++;
                if ((k % 2 == 1) && !(m1_rvalid && !m0_rvalid && m1_rdata == 32'h22222222)) errs++;
            end else if (m0_rvalid || m1_rvalid) errs++;
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("mixed_ids", errs, 0);

        // reset with two reads in flight: the m1 read must never return
        issue(0, 0, 6'h05, 32'h0);
        issue(1, 0, 6'h3F, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 1);
        chk("mid_rst_cs", {31'b0, ram_cs}, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("restart_adr0", {ram_cs, ram_we, ram_adr}, {1'b1, 1'b1, 6'h00});
        chk("restart_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("restart_adr1", {ram_cs, ram_we, ram_adr}, {1'b1, 1'b1, 6'h01});
        chk("restart_busy", {31'b0, busy}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
